// File: rtl/fp_seq_pkg.sv
// Shared types and constants for the FP frame sequencer: state encoding,
// opcode and error-code values, start-byte prefix and the result compare.
package fp_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_COLLECT  = 3'd1,
    S_LAUNCH   = 3'd2,
    S_WAIT_FPU = 3'd3,
    S_REPORT   = 3'd4
  } state_t;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  localparam logic [1:0] ERR_NONE       = 2'b00;
  localparam logic [1:0] ERR_RX_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_BAD_OP     = 2'b10;
  localparam logic [1:0] ERR_OVERRUN    = 2'b11;

  localparam logic [5:0] START_PREFIX  = 6'b111111;
  localparam int         PAYLOAD_BYTES = 12;

  // Bitwise equality, except that +0 and -0 are treated as the same value.
  function automatic logic fp_equal(input logic [31:0] x, input logic [31:0] y);
    return (x == y) || ((x[30:0] == 31'd0) && (y[30:0] == 31'd0));
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Loadable down-counter watchdog. load arms it with TIMEOUT-1, each enabled
// cycle counts down, and expire is raised in the enabled cycle in which the
// count has reached zero (i.e. the TIMEOUT-th enabled cycle after a load).
module seq_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  // Down-counter: load has priority over clear, counting stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(TIMEOUT - 1);
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expire = en && !load && !clr && (cnt == '0);

endmodule

// File: rtl/fp_frame_sequencer.sv
// Frame sequencer between the I2C byte receiver and the FPU: finds the start
// byte, collects A/B/expected words, launches the FPU and reports the result.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | waiting for a start byte, counting dropped bytes
// S_COLLECT  | shifting in the 12 payload bytes, RX idle watchdog armed
// S_LAUNCH   | drive operands, pulse fpu_start, arm FPU watchdog
// S_WAIT_FPU | waiting for fpu_done; stray bytes are overrun errors
// S_REPORT   | res_* valid pulse cycle, then back to idle
module fp_frame_sequencer
  import fp_seq_pkg::*;
#(
  parameter int RX_TIMEOUT  = 100000,
  parameter int FPU_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        fpu_start,
  output logic [1:0]  fpu_op,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  input  logic        fpu_done,
  input  logic [31:0] fpu_result,
  output logic        res_valid,
  output logic [31:0] res_value,
  output logic [31:0] res_expected,
  output logic        res_match,
  output logic        busy,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [7:0]  drop_cnt
);

  state_t      state;
  logic [1:0]  op_q;
  logic [3:0]  byte_cnt;
  logic [95:0] frame_buf;

  logic rx_is_start;
  logic rx_good_start;
  logic rx_clr, rx_load, rx_en, rx_expire;
  logic fpu_clr, fpu_load, fpu_en, fpu_expire;

  assign rx_is_start   = (rx_data[7:2] == START_PREFIX);
  assign rx_good_start = rx_valid && rx_is_start && (rx_data[1:0] != OP_RSVD);
  assign busy          = (state != S_IDLE);

  // Watchdog control decoded from the current state.
  always_comb begin
    rx_clr   = 1'b0;
    rx_load  = 1'b0;
    rx_en    = 1'b0;
    fpu_clr  = 1'b0;
    fpu_load = 1'b0;
    fpu_en   = 1'b0;
    case (state)
      S_IDLE: begin
        rx_clr  = 1'b1;
        fpu_clr = 1'b1;
        rx_load = rx_good_start;
      end
      S_COLLECT: begin
        rx_en   = 1'b1;
        rx_load = rx_valid;
      end
      S_LAUNCH:   fpu_load = 1'b1;
      S_WAIT_FPU: fpu_en   = 1'b1;
      default: ;
    endcase
  end

  seq_watchdog #(.TIMEOUT(RX_TIMEOUT)) u_rx_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (rx_clr),
    .load   (rx_load),
    .en     (rx_en),
    .expire (rx_expire)
  );

  seq_watchdog #(.TIMEOUT(FPU_TIMEOUT)) u_fpu_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (fpu_clr),
    .load   (fpu_load),
    .en     (fpu_en),
    .expire (fpu_expire)
  );

  // Sequencer FSM with registered handshake, result and error outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      op_q         <= OP_ADD;
      byte_cnt     <= 4'd0;
      frame_buf    <= 96'd0;
      fpu_start    <= 1'b0;
      fpu_op       <= OP_ADD;
      fpu_a        <= 32'd0;
      fpu_b        <= 32'd0;
      res_valid    <= 1'b0;
      res_value    <= 32'd0;
      res_expected <= 32'd0;
      res_match    <= 1'b0;
      frame_err    <= 1'b0;
      err_code     <= ERR_NONE;
      drop_cnt     <= 8'd0;
    end else begin
      fpu_start <= 1'b0;
      res_valid <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_good_start) begin
            op_q     <= rx_data[1:0];
            byte_cnt <= 4'd0;
            state    <= S_COLLECT;
          end else if (rx_valid && rx_is_start) begin
            frame_err <= 1'b1;
            err_code  <= ERR_BAD_OP;
          end else if (rx_valid && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
          end
        end
        S_COLLECT: begin
          // A byte in the expiry cycle is accepted and the timeout is ignored.
          if (rx_valid) begin
            frame_buf <= {frame_buf[87:0], rx_data};
            byte_cnt  <= byte_cnt + 4'd1;
            if (byte_cnt == 4'(PAYLOAD_BYTES - 1)) begin
              state <= S_LAUNCH;
            end
          end else if (rx_expire) begin
            frame_err <= 1'b1;
            err_code  <= ERR_RX_TIMEOUT;
            state     <= S_IDLE;
          end
        end
        S_LAUNCH: begin
          fpu_a     <= frame_buf[95:64];
          fpu_b     <= frame_buf[63:32];
          fpu_op    <= op_q;
          fpu_start <= 1'b1;
          state     <= S_WAIT_FPU;
          if (rx_valid) begin
            frame_err <= 1'b1;
            err_code  <= ERR_OVERRUN;
          end
        end
        S_WAIT_FPU: begin
          // Overrun byte is discarded but does not abort the operation.
          if (rx_valid) begin
            frame_err <= 1'b1;
            err_code  <= ERR_OVERRUN;
          end
          if (fpu_done) begin
            res_value    <= fpu_result;
            res_expected <= frame_buf[31:0];
            res_match    <= fp_equal(fpu_result, frame_buf[31:0]);
            res_valid    <= 1'b1;
            state        <= S_REPORT;
          end else if (fpu_expire) begin
            frame_err <= 1'b1;
            err_code  <= ERR_OVERRUN;
            state     <= S_IDLE;
          end
        end
        S_REPORT: begin
          state <= S_IDLE;
          if (rx_valid && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_frame_sequencer.sv
// Scoreboard bench for fp_frame_sequencer: directed frames push expected
// launches, results and errors into queues; a negedge monitor pops and checks.
module tb_fp_frame_sequencer;

  localparam int RX_TO  = 64;
  localparam int FPU_TO = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        fpu_start;
  logic [1:0]  fpu_op;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic        fpu_done;
  logic [31:0] fpu_result;
  logic        res_valid;
  logic [31:0] res_value;
  logic [31:0] res_expected;
  logic        res_match;
  logic        busy;
  logic        frame_err;
  logic [1:0]  err_code;
  logic [7:0]  drop_cnt;

  fp_frame_sequencer #(.RX_TIMEOUT(RX_TO), .FPU_TIMEOUT(FPU_TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .fpu_start    (fpu_start),
    .fpu_op       (fpu_op),
    .fpu_a        (fpu_a),
    .fpu_b        (fpu_b),
    .fpu_done     (fpu_done),
    .fpu_result   (fpu_result),
    .res_valid    (res_valid),
    .res_value    (res_value),
    .res_expected (res_expected),
    .res_match    (res_match),
    .busy         (busy),
    .frame_err    (frame_err),
    .err_code     (err_code),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int last_byte_cyc = 0;
  int done_cyc = 0;

  typedef struct { logic [1:0] op; logic [31:0] a; logic [31:0] b; } launch_t;
  typedef struct { logic [31:0] val; logic [31:0] exp; logic match; } res_t;

  launch_t    launch_q[$];
  res_t       res_q[$];
  logic [1:0] err_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every DUT event must match the oldest queued expectation.
  always @(negedge clk) begin
    launch_t l;
    res_t    r;
    logic [1:0] e;
    if (rst_n) begin
      if (fpu_start) begin
        if (launch_q.size() == 0) chk("unexpected_fpu_start", 32'd1, 32'd0);
        else begin
          l = launch_q.pop_front();
          chk("fpu_op", {30'd0, fpu_op}, {30'd0, l.op});
          chk("fpu_a", fpu_a, l.a);
          chk("fpu_b", fpu_b, l.b);
          chk("start_latency", 32'(cyc), 32'(last_byte_cyc + 2));
        end
      end
      if (res_valid) begin
        if (res_q.size() == 0) chk("unexpected_res_valid", 32'd1, 32'd0);
        else begin
          r = res_q.pop_front();
          chk("res_value", res_value, r.val);
          chk("res_expected", res_expected, r.exp);
          chk("res_match", {31'd0, res_match}, {31'd0, r.match});
          chk("res_latency", 32'(cyc), 32'(done_cyc + 1));
        end
      end
      if (frame_err) begin
        if (err_q.size() == 0) chk("unexpected_frame_err", 32'd1, 32'd0);
        else begin
          e = err_q.pop_front();
          chk("err_code", {30'd0, err_code}, {30'd0, e});
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid      = 1'b1;
    rx_data       = b;
    last_byte_cyc = cyc;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] e);
    logic [95:0] p;
    p = {a, b, e};
    send_byte({6'b111111, op});
    for (int i = 0; i < 12; i++) send_byte(p[95 - 8*i -: 8]);
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (fpu_start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("wait_fpu_start_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_done(input logic [31:0] r);
    fpu_done   = 1'b1;
    fpu_result = r;
    done_cyc   = cyc;
    @(negedge clk);
    fpu_done = 1'b0;
  endtask

  task automatic respond(input int lat, input logic [31:0] r);
    bit ok;
    wait_start(ok);
    if (ok) begin
      repeat (lat) @(negedge clk);
      pulse_done(r);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk(name, 32'd1, 32'd0);
  endtask

  task automatic full_frame(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] e, input logic [31:0] r, input logic m, input int lat);
    launch_q.push_back('{op: op, a: a, b: b});
    res_q.push_back('{val: r, exp: e, match: m});
    send_frame(op, a, b, e);
    respond(lat, r);
    wait_idle(20, "idle_after_frame_timeout");
  endtask

  initial begin
    bit ok;
    rst_n      = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    fpu_done   = 1'b0;
    fpu_result = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    chk("reset_err_code", {30'd0, err_code}, 32'd0);
    chk("reset_fpu_a", fpu_a, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: mul frame, matching result after 5 cycles
    launch_q.push_back('{op: 2'b10, a: 32'h40400000, b: 32'h3F000000});
    res_q.push_back('{val: 32'h3FC00000, exp: 32'h3FC00000, match: 1'b1});
    send_frame(2'b10, 32'h40400000, 32'h3F000000, 32'h3FC00000);
    chk("busy_after_payload", {31'd0, busy}, 32'd1);
    respond(5, 32'h3FC00000);
    wait_idle(20, "idle_t1_timeout");

    // 2: two dropped bytes, then a mismatching result
    send_byte(8'hF0);
    send_byte(8'h0F);
    chk("drop_cnt_two", {24'd0, drop_cnt}, 32'd2);
    full_frame(2'b10, 32'h12345678, 32'h87654321, 32'hFFFFFFFF, 32'h00000000, 1'b0, 3);

    // 3: partial frame, RX timeout exactly RX_TO idle cycles after the last byte
    err_q.push_back(2'b01);
    send_byte(8'hFE);
    for (int i = 0; i < 5; i++) send_byte(8'h11 * 8'(i + 1));
    repeat (RX_TO - 1) @(negedge clk);
    chk("busy_before_rx_timeout", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("busy_after_rx_timeout", {31'd0, busy}, 32'd0);
    chk("err_code_held_rx", {30'd0, err_code}, 32'd1);
    full_frame(2'b10, 32'h40400000, 32'h3F000000, 32'h3FC00000, 32'h3FC00000, 1'b1, 5);

    // 4: reserved opcode, then add frame, then +0 vs -0 compare
    err_q.push_back(2'b10);
    send_byte(8'hFF);
    chk("busy_bad_op", {31'd0, busy}, 32'd0);
    chk("drop_cnt_bad_op", {24'd0, drop_cnt}, 32'd2);
    full_frame(2'b00, 32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40000000, 1'b1, 2);
    full_frame(2'b01, 32'h3F800000, 32'h3F800000, 32'h80000000, 32'h00000000, 1'b1, 0);

    // 5: overrun byte coincident with fpu_done, then FPU timeout
    launch_q.push_back('{op: 2'b01, a: 32'h40000000, b: 32'h3F800000});
    err_q.push_back(2'b11);
    res_q.push_back('{val: 32'h3F800000, exp: 32'h3F800000, match: 1'b1});
    send_frame(2'b01, 32'h40000000, 32'h3F800000, 32'h3F800000);
    wait_start(ok);
    repeat (3) @(negedge clk);
    rx_valid   = 1'b1;
    rx_data    = 8'hAA;
    fpu_done   = 1'b1;
    fpu_result = 32'h3F800000;
    done_cyc   = cyc;
    @(negedge clk);
    rx_valid = 1'b0;
    fpu_done = 1'b0;
    chk("fpu_a_stable", fpu_a, 32'h40000000);
    chk("fpu_b_stable", fpu_b, 32'h3F800000);
    wait_idle(20, "idle_t5_timeout");
    chk("drop_cnt_overrun", {24'd0, drop_cnt}, 32'd2);

    launch_q.push_back('{op: 2'b10, a: 32'h00000001, b: 32'h00000002});
    err_q.push_back(2'b11);
    send_frame(2'b10, 32'h00000001, 32'h00000002, 32'h00000003);
    wait_start(ok);
    repeat (FPU_TO - 1) @(negedge clk);
    chk("busy_before_fpu_timeout", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("busy_after_fpu_timeout", {31'd0, busy}, 32'd0);

    // 6: reset during WAIT_FPU, late fpu_done ignored
    launch_q.push_back('{op: 2'b10, a: 32'h3F800000, b: 32'h40000000});
    send_frame(2'b10, 32'h3F800000, 32'h40000000, 32'h40000000);
    wait_start(ok);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fpu_start", {31'd0, fpu_start}, 32'd0);
    chk("rst_fpu_op", {30'd0, fpu_op}, 32'd0);
    chk("rst_fpu_a", fpu_a, 32'd0);
    chk("rst_fpu_b", fpu_b, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_value", res_value, 32'd0);
    chk("rst_res_expected", res_expected, 32'd0);
    chk("rst_res_match", {31'd0, res_match}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_err_code", {30'd0, err_code}, 32'd0);
    chk("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    pulse_done(32'h40000000);
    repeat (5) @(negedge clk);
    chk("busy_after_late_done", {31'd0, busy}, 32'd0);

    chk("launch_q_empty", 32'(launch_q.size()), 32'd0);
    chk("res_q_empty", 32'(res_q.size()), 32'd0);
    chk("err_q_empty", 32'(err_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
